// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decides taken/not-taken, issues a one-cycle
// fetch redirect on mispredict, squashes wrong-path EX slots and keeps statistics.
module branch_resolve #(
  parameter int Width       = 32,
  parameter int CntWidth    = 16,
  parameter int SquashDepth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ex_valid_i,
  input  logic                ex_branch_i,
  input  logic                ex_jalr_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [Width-1:0]    ex_pc_i,
  input  logic [Width-1:0]    ex_target_i,
  input  logic                stall_i,
  input  logic                BrLt,
  input  logic                BrEq,
  input  logic                clr_cnt_i,
  output logic                BrUn,
  output logic                flush_o,
  output logic [Width-1:0]    redirect_pc_o,
  output logic                squash_o,
  output logic [CntWidth-1:0] branch_cnt_o,
  output logic [CntWidth-1:0] mispred_cnt_o
);

  localparam int SqW = (SquashDepth < 1) ? 1 : $clog2(SquashDepth + 1);

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t           state, state_next;
  logic [SqW-1:0]   sq_cnt, sq_cnt_next;
  logic             taken, f3_ok;
  logic             can_resolve, br_resolve, jalr_resolve, mispredict;
  logic [Width-1:0] redirect_target;

  assign BrUn = (ex_funct3_i[2:1] == 2'b11);

  always_comb begin
    taken = 1'b0;
    f3_ok = 1'b1;
    case (ex_funct3_i)
      3'b000:          taken = BrEq;
      3'b001:          taken = !BrEq;
      3'b100, 3'b110:  taken = BrLt;
      3'b101, 3'b111:  taken = !BrLt;
      default:         f3_ok = 1'b0;
    endcase
  end

  // JALR takes precedence if both decode flags are ever raised together.
  assign can_resolve  = ex_valid_i && !stall_i && (state == IDLE);
  assign jalr_resolve = can_resolve && ex_jalr_i;
  assign br_resolve   = can_resolve && ex_branch_i && f3_ok && !ex_jalr_i;
  assign mispredict   = jalr_resolve || (br_resolve && !taken);

  // Fetch predicts taken, so a branch mispredict always falls through to pc+4.
  assign redirect_target = ex_jalr_i ? {ex_target_i[Width-1:1], 1'b0}
                                     : ex_pc_i + Width'(4);

  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_next  = SQUASH;
          sq_cnt_next = SqW'(SquashDepth);
        end
      end
      SQUASH: begin
        if (!stall_i) begin
          if (sq_cnt <= SqW'(1)) begin
            state_next  = IDLE;
            sq_cnt_next = '0;
          end else begin
            sq_cnt_next = sq_cnt - SqW'(1);
          end
        end
      end
      default: begin
        state_next  = IDLE;
        sq_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      sq_cnt <= '0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_cnt_next;
    end
  end

  assign squash_o = (state == SQUASH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      flush_o <= mispredict;
      if (mispredict) redirect_pc_o <= redirect_target;
    end
  end

  // Clear beats any same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (br_resolve && (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + CntWidth'(1);
      if (mispredict && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: each task drives one scenario and checks
// outputs against hand-computed values, sampling 1 ns after the rising edge.
module tb_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_branch_i, ex_jalr_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i, ex_target_i;
  logic        stall_i, BrLt, BrEq, clr_cnt_i;
  logic        BrUn, flush_o, squash_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_cnt_o, mispred_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_br  = 16'd0;
  logic [15:0] exp_mis = 16'd0;

  branch_resolve #(.Width(32), .CntWidth(16), .SquashDepth(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ex_valid_i    (ex_valid_i),
    .ex_branch_i   (ex_branch_i),
    .ex_jalr_i     (ex_jalr_i),
    .ex_funct3_i   (ex_funct3_i),
    .ex_pc_i       (ex_pc_i),
    .ex_target_i   (ex_target_i),
    .stall_i       (stall_i),
    .BrLt          (BrLt),
    .BrEq          (BrEq),
    .clr_cnt_i     (clr_cnt_i),
    .BrUn          (BrUn),
    .flush_o       (flush_o),
    .redirect_pc_o (redirect_pc_o),
    .squash_o      (squash_o),
    .branch_cnt_o  (branch_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_i  = 1'b0;
    ex_branch_i = 1'b0;
    ex_jalr_i   = 1'b0;
    ex_funct3_i = 3'b000;
    ex_pc_i     = 32'h0;
    ex_target_i = 32'h0;
    stall_i     = 1'b0;
    BrLt        = 1'b0;
    BrEq        = 1'b0;
    clr_cnt_i   = 1'b0;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic lt, input logic eq);
    ex_valid_i  = 1'b1;
    ex_branch_i = 1'b1;
    ex_jalr_i   = 1'b0;
    ex_funct3_i = f3;
    ex_pc_i     = pc;
    ex_target_i = tgt;
    BrLt        = lt;
    BrEq        = eq;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %0b want 0", flush_o); end
    tests_run++; if (squash_o !== 1'b0) begin tests_failed++; $display("FAIL reset_squash: got %0b want 0", squash_o); end
    tests_run++; if (redirect_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_redirect: got %h want 0", redirect_pc_o); end
    tests_run++; if (branch_cnt_o !== 16'h0 || mispred_cnt_o !== 16'h0) begin tests_failed++; $display("FAIL reset_counts: got %h/%h want 0/0", branch_cnt_o, mispred_cnt_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_invalid_funct3();
    drive_branch(3'b011, 32'h80, 32'hC0, 1'b0, 1'b0);
    #1;
    tests_run++; if (BrUn !== 1'b0) begin tests_failed++; $display("FAIL brun_011: got %0b want 0", BrUn); end
    step();
    idle_inputs();
    tests_run++; if (flush_o !== 1'b0 || squash_o !== 1'b0) begin tests_failed++; $display("FAIL invalid_f3_flush: got %0b/%0b want 0/0", flush_o, squash_o); end
    tests_run++; if (branch_cnt_o !== exp_br) begin tests_failed++; $display("FAIL invalid_f3_count: got %h want %h", branch_cnt_o, exp_br); end
  endtask

  task automatic test_beq_taken();
    drive_branch(3'b000, 32'h100, 32'h180, 1'b0, 1'b1);
    #1;
    tests_run++; if (BrUn !== 1'b0) begin tests_failed++; $display("FAIL brun_beq: got %0b want 0", BrUn); end
    step();
    idle_inputs();
    exp_br = exp_br + 16'd1;
    tests_run++; if (flush_o !== 1'b0 || squash_o !== 1'b0) begin tests_failed++; $display("FAIL beq_no_flush: got %0b/%0b want 0/0", flush_o, squash_o); end
    tests_run++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin tests_failed++; $display("FAIL beq_counts: got %h/%h want %h/%h", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis); end
  endtask

  task automatic test_bne_mispredict();
    drive_branch(3'b001, 32'h100, 32'h180, 1'b0, 1'b1);
    step();
    exp_br  = exp_br + 16'd1;
    exp_mis = exp_mis + 16'd1;
    tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("FAIL bne_flush: got %0b want 1", flush_o); end
    tests_run++; if (redirect_pc_o !== 32'h104) begin tests_failed++; $display("FAIL bne_redirect: got %h want 00000104", redirect_pc_o); end
    tests_run++; if (squash_o !== 1'b1) begin tests_failed++; $display("FAIL bne_squash1: got %0b want 1", squash_o); end
    // wrong-path slots carry valid mispredicting branches that must be ignored
    drive_branch(3'b001, 32'h104, 32'h200, 1'b0, 1'b1);
    step();
    tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL bne_flush_drop: got %0b want 0", flush_o); end
    tests_run++; if (squash_o !== 1'b1) begin tests_failed++; $display("FAIL bne_squash2: got %0b want 1", squash_o); end
    tests_run++; if (redirect_pc_o !== 32'h104) begin tests_failed++; $display("FAIL bne_redirect_hold: got %h want 00000104", redirect_pc_o); end
    step();
    idle_inputs();
    tests_run++; if (squash_o !== 1'b0 || flush_o !== 1'b0) begin tests_failed++; $display("FAIL bne_squash_end: got %0b/%0b want 0/0", squash_o, flush_o); end
    tests_run++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin tests_failed++; $display("FAIL bne_counts: got %h/%h want %h/%h", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis); end
  endtask

  task automatic test_unsigned_and_bge();
    drive_branch(3'b110, 32'h200, 32'h300, 1'b0, 1'b0);
    #1;
    tests_run++; if (BrUn !== 1'b1) begin tests_failed++; $display("FAIL brun_bltu: got %0b want 1", BrUn); end
    step();
    idle_inputs();
    exp_br  = exp_br + 16'd1;
    exp_mis = exp_mis + 16'd1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h204) begin tests_failed++; $display("FAIL bltu_redirect: got %0b/%h want 1/00000204", flush_o, redirect_pc_o); end
    step();
    step();
    tests_run++; if (squash_o !== 1'b0) begin tests_failed++; $display("FAIL bltu_squash_end: got %0b want 0", squash_o); end
    drive_branch(3'b101, 32'h220, 32'h400, 1'b0, 1'b0);
    #1;
    tests_run++; if (BrUn !== 1'b0) begin tests_failed++; $display("FAIL brun_bge: got %0b want 0", BrUn); end
    step();
    idle_inputs();
    exp_br = exp_br + 16'd1;
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h204) begin tests_failed++; $display("FAIL bge_taken: got %0b/%h want 0/00000204", flush_o, redirect_pc_o); end
    tests_run++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin tests_failed++; $display("FAIL bge_counts: got %h/%h want %h/%h", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis); end
  endtask

  task automatic test_pc_wrap();
    drive_branch(3'b100, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0);
    #1;
    tests_run++; if (BrUn !== 1'b0) begin tests_failed++; $display("FAIL brun_blt: got %0b want 0", BrUn); end
    step();
    idle_inputs();
    exp_br  = exp_br + 16'd1;
    exp_mis = exp_mis + 16'd1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_redirect: got %0b/%h want 1/00000000", flush_o, redirect_pc_o); end
    step();
    step();
  endtask

  task automatic test_jalr_stall();
    logic exp_sq;
    idle_inputs();
    ex_valid_i  = 1'b1;
    ex_jalr_i   = 1'b1;
    ex_funct3_i = 3'b000;
    ex_pc_i     = 32'h300;
    ex_target_i = 32'h2001;
    step();
    idle_inputs();
    exp_mis = exp_mis + 16'd1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h2000) begin tests_failed++; $display("FAIL jalr_redirect: got %0b/%h want 1/00002000", flush_o, redirect_pc_o); end
    // squash cycles 1..3 stalled, so squash_o stays up for 5 cycles in total
    for (int k = 1; k <= 6; k++) begin
      stall_i = (k <= 3);
      exp_sq  = (k <= 5);
      if (k == 1) begin
        tests_run++; if (squash_o !== exp_sq) begin tests_failed++; $display("FAIL jalr_squash_c%0d: got %0b want %0b", k, squash_o, exp_sq); end
      end
      if (k == 2) begin
        tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL jalr_flush_stalled: got %0b want 0", flush_o); end
      end
      if (k < 6) step();
      if (k < 6) begin
        exp_sq = (k + 1 <= 5);
        tests_run++; if (squash_o !== exp_sq) begin tests_failed++; $display("FAIL jalr_squash_c%0d: got %0b want %0b", k + 1, squash_o, exp_sq); end
      end
    end
    idle_inputs();
    tests_run++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin tests_failed++; $display("FAIL jalr_counts: got %h/%h want %h/%h", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis); end
  endtask

  task automatic test_saturate_and_clear();
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    exp_br  = 16'h0;
    exp_mis = 16'h0;
    tests_run++; if (branch_cnt_o !== 16'h0 || mispred_cnt_o !== 16'h0) begin tests_failed++; $display("FAIL clr_counts: got %h/%h want 0/0", branch_cnt_o, mispred_cnt_o); end
    drive_branch(3'b000, 32'h500, 32'h600, 1'b0, 1'b1);
    repeat (65535) step();
    tests_run++; if (branch_cnt_o !== 16'hFFFF) begin tests_failed++; $display("FAIL preload_count: got %h want ffff", branch_cnt_o); end
    step();
    tests_run++; if (branch_cnt_o !== 16'hFFFF) begin tests_failed++; $display("FAIL saturate_count: got %h want ffff", branch_cnt_o); end
    tests_run++; if (mispred_cnt_o !== 16'h0 || flush_o !== 1'b0) begin tests_failed++; $display("FAIL saturate_no_mis: got %h/%0b want 0/0", mispred_cnt_o, flush_o); end
    drive_branch(3'b001, 32'h700, 32'h800, 1'b0, 1'b1);
    clr_cnt_i = 1'b1;
    step();
    idle_inputs();
    tests_run++; if (branch_cnt_o !== 16'h0 || mispred_cnt_o !== 16'h0) begin tests_failed++; $display("FAIL clr_wins: got %h/%h want 0/0", branch_cnt_o, mispred_cnt_o); end
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h704) begin tests_failed++; $display("FAIL clr_mispredict_flush: got %0b/%h want 1/00000704", flush_o, redirect_pc_o); end
    step();
    step();
  endtask

  task automatic test_reset_abort();
    drive_branch(3'b001, 32'h900, 32'hA00, 1'b0, 1'b1);
    step();
    idle_inputs();
    tests_run++; if (flush_o !== 1'b1 || squash_o !== 1'b1) begin tests_failed++; $display("FAIL abort_pre: got %0b/%0b want 1/1", flush_o, squash_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    exp_br  = 16'h0;
    exp_mis = 16'h0;
    tests_run++; if (flush_o !== 1'b0 || squash_o !== 1'b0) begin tests_failed++; $display("FAIL abort_async: got %0b/%0b want 0/0", flush_o, squash_o); end
    tests_run++; if (redirect_pc_o !== 32'h0) begin tests_failed++; $display("FAIL abort_redirect: got %h want 0", redirect_pc_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive_branch(3'b001, 32'h400, 32'h480, 1'b0, 1'b1);
    step();
    idle_inputs();
    exp_br  = 16'd1;
    exp_mis = 16'd1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h404) begin tests_failed++; $display("FAIL first_after_reset: got %0b/%h want 1/00000404", flush_o, redirect_pc_o); end
    tests_run++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin tests_failed++; $display("FAIL first_after_reset_counts: got %h/%h want %h/%h", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis); end
    step();
    step();
    tests_run++; if (flush_o !== 1'b0 || squash_o !== 1'b0) begin tests_failed++; $display("FAIL after_reset_idle: got %0b/%0b want 0/0", flush_o, squash_o); end
  endtask

  initial begin
    test_reset();
    test_invalid_funct3();
    test_beq_taken();
    test_bne_mispredict();
    test_unsigned_and_bge();
    test_pc_wrap();
    test_jalr_stall();
    test_saturate_and_clear();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
